// File: rtl/uart_bridge_pkg.sv
// Shared definitions for the UART command bridge.
//   bridgeState_t : command engine states
//   OP_* / RSP_*  : host opcodes and response bytes
package uart_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    WR_ISSUE,
    RD_ISSUE,
    RD_WAIT,
    SEND
  } bridgeState_t;

  localparam logic [7:0] OP_WRITE = 8'h57;  // 'W'
  localparam logic [7:0] OP_READ  = 8'h52;  // 'R'
  localparam logic [7:0] RSP_ACK  = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_ERR  = 8'h45;  // 'E'
  localparam logic [7:0] RSP_TMO  = 8'h54;  // 'T'

endpackage

// File: rtl/uart_cmd_bridge.sv
// Host command engine between the UART FIFOs and a simple register bus.
// 'W' addr data -> register write, replies 'K'
// 'R' addr      -> register read, replies with the read byte
// other opcode  -> replies 'E'; inter-byte stall -> replies 'T'
// Ports:
//   Clock, ResetN            : clock, async active-low reset
//   RxEmpty/ReadData/ReadUart: RX FIFO head and pop
//   TxFull/WriteData/WriteUart: TX FIFO push
//   RegAddr/RegWrData/RegWrEn/RegRdEn/RegRdData : register bus
//   Busy                     : command in progress
module uart_cmd_bridge
  import uart_bridge_pkg::*;
#(
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned ADDR_BITS      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 104167
) (
  input  logic                 Clock,
  input  logic                 ResetN,
  input  logic                 RxEmpty,
  input  logic [DATA_BITS-1:0] ReadData,
  output logic                 ReadUart,
  input  logic                 TxFull,
  output logic [DATA_BITS-1:0] WriteData,
  output logic                 WriteUart,
  output logic [ADDR_BITS-1:0] RegAddr,
  output logic [DATA_BITS-1:0] RegWrData,
  output logic                 RegWrEn,
  output logic                 RegRdEn,
  input  logic [DATA_BITS-1:0] RegRdData,
  output logic                 Busy
);

  localparam int unsigned CNT_BITS = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(TIMEOUT_CYCLES - 1);

  bridgeState_t state, nextState;
  logic                isWrite;
  logic [CNT_BITS-1:0] timeoutCnt;
  logic                inGather;
  logic                timeoutHit;
  logic                opIsWrite;
  logic                opIsRead;

  assign opIsWrite  = (ReadData == DATA_BITS'(OP_WRITE));
  assign opIsRead   = (ReadData == DATA_BITS'(OP_READ));
  assign inGather   = (state == GET_ADDR) || (state == GET_DATA);
  // A byte present on the terminal-count cycle is popped instead of timing out.
  assign timeoutHit = inGather && RxEmpty && (timeoutCnt == CNT_LAST);
  assign Busy       = (state != IDLE);

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) state <= IDLE;
    else         state <= nextState;
  end

  always_comb begin
    nextState = state;
    ReadUart  = 1'b0;
    WriteUart = 1'b0;
    RegWrEn   = 1'b0;
    RegRdEn   = 1'b0;
    case (state)
      IDLE: begin
        ReadUart = ~RxEmpty;
        if (!RxEmpty) nextState = (opIsWrite || opIsRead) ? GET_ADDR : SEND;
      end
      GET_ADDR: begin
        ReadUart = ~RxEmpty;
        if (!RxEmpty)        nextState = isWrite ? GET_DATA : RD_ISSUE;
        else if (timeoutHit) nextState = SEND;
      end
      GET_DATA: begin
        ReadUart = ~RxEmpty;
        if (!RxEmpty)        nextState = WR_ISSUE;
        else if (timeoutHit) nextState = SEND;
      end
      WR_ISSUE: begin
        RegWrEn   = 1'b1;
        nextState = SEND;
      end
      RD_ISSUE: begin
        RegRdEn   = 1'b1;
        nextState = RD_WAIT;
      end
      RD_WAIT:  nextState = SEND;
      SEND: begin
        WriteUart = ~TxFull;
        if (!TxFull) nextState = IDLE;
      end
      default:  nextState = IDLE;
    endcase
  end

  // WriteData doubles as the response register so it stays stable through SEND.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      isWrite    <= 1'b0;
      RegAddr    <= '0;
      RegWrData  <= '0;
      WriteData  <= '0;
      timeoutCnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ReadUart) begin
            isWrite <= opIsWrite;
            if (!opIsWrite && !opIsRead) WriteData <= DATA_BITS'(RSP_ERR);
          end
        end
        GET_ADDR: begin
          if (ReadUart)        RegAddr   <= ReadData[ADDR_BITS-1:0];
          else if (timeoutHit) WriteData <= DATA_BITS'(RSP_TMO);
        end
        GET_DATA: begin
          if (ReadUart)        RegWrData <= ReadData;
          else if (timeoutHit) WriteData <= DATA_BITS'(RSP_TMO);
        end
        WR_ISSUE: WriteData <= DATA_BITS'(RSP_ACK);
        RD_WAIT:  WriteData <= RegRdData;
        default:  ;
      endcase

      // Entry into GET_ADDR/GET_DATA always coincides with a pop, which clears.
      if (inGather && !ReadUart && !timeoutHit) timeoutCnt <= timeoutCnt + CNT_BITS'(1);
      else                                      timeoutCnt <= '0;
    end
  end

endmodule

// File: tb/tb_uart_cmd_bridge.sv
module tb_uart_cmd_bridge;

  typedef struct {
    logic [7:0] data;
    int         gap;   // idle cycles after the previous pop before this byte shows
  } rxItem_t;

  typedef struct {
    bit         isWr;
    logic [7:0] addr;
    logic [7:0] data;
  } busOp_t;

  logic       Clock;
  logic       ResetN;
  logic       RxEmpty;
  logic [7:0] ReadData;
  logic       ReadUart;
  logic       TxFull;
  logic [7:0] WriteData;
  logic       WriteUart;
  logic [7:0] RegAddr;
  logic [7:0] RegWrData;
  logic       RegWrEn;
  logic       RegRdEn;
  logic [7:0] RegRdData;
  logic       Busy;

  rxItem_t    rxQ[$];
  logic [7:0] expResp[$];
  busOp_t     expBus[$];
  logic [7:0] rdValue;
  int         passCnt = 0;
  int         totalCnt = 0;

  uart_cmd_bridge #(
    .DATA_BITS(8),
    .ADDR_BITS(8),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .Clock(Clock),
    .ResetN(ResetN),
    .RxEmpty(RxEmpty),
    .ReadData(ReadData),
    .ReadUart(ReadUart),
    .TxFull(TxFull),
    .WriteData(WriteData),
    .WriteUart(WriteUart),
    .RegAddr(RegAddr),
    .RegWrData(RegWrData),
    .RegWrEn(RegWrEn),
    .RegRdEn(RegRdEn),
    .RegRdData(RegRdData),
    .Busy(Busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endfunction

  task automatic pushRx(input logic [7:0] data, input int gap);
    rxItem_t it;
    it.data = data;
    it.gap  = gap;
    rxQ.push_back(it);
  endtask

  task automatic expectBus(input bit isWr, input logic [7:0] addr, input logic [7:0] data);
    busOp_t op;
    op.isWr = isWr;
    op.addr = addr;
    op.data = data;
    expBus.push_back(op);
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (!(rxQ.size() == 0 && expResp.size() == 0 && expBus.size() == 0 && !Busy) && n < budget) begin
      @(negedge Clock);
      n++;
    end
    totalCnt++;
    if (n < budget) passCnt++;
    else $display("FAIL drain_%s: still busy after %0d cycles, expected idle (resp left %0d, bus left %0d)",
                  tag, n, expResp.size(), expBus.size());
  endtask

  // RX FIFO model: pops on edges where ReadUart was high, presents the next byte
  // once its gap has elapsed.
  initial begin
    bit      willPop;
    int      gapCnt;
    rxItem_t tmp;
    RxEmpty  = 1'b1;
    ReadData = 8'hEE;
    gapCnt   = 1000;
    forever begin
      @(negedge Clock);
      willPop = ReadUart;
      @(posedge Clock);
      #1;
      if (willPop && ResetN) begin
        tmp    = rxQ.pop_front();
        gapCnt = 0;
      end else if (gapCnt < 100000) begin
        gapCnt++;
      end
      if (rxQ.size() > 0 && gapCnt >= rxQ[0].gap) begin
        RxEmpty  = 1'b0;
        ReadData = rxQ[0].data;
      end else begin
        RxEmpty  = 1'b1;
        ReadData = 8'hEE;
      end
    end
  end

  // Register responder: read data is valid only in the cycle after RegRdEn.
  initial begin
    bit seen;
    RegRdData = 8'hFF;
    forever begin
      @(negedge Clock);
      seen = RegRdEn;
      @(posedge Clock);
      #1;
      RegRdData = seen ? rdValue : 8'hFF;
    end
  end

  // Monitor / scoreboard.
  always @(negedge Clock) begin
    busOp_t op;
    if (RxEmpty) check("readuart_while_empty", {31'b0, ReadUart}, 32'd0);
    if (TxFull)  check("writeuart_while_full", {31'b0, WriteUart}, 32'd0);
    if (WriteUart) begin
      if (expResp.size() == 0) begin
        totalCnt++;
        $display("FAIL unexpected_push: got 0x%0h expected none at %0t", WriteData, $time);
      end else begin
        check("resp_byte", {24'b0, WriteData}, {24'b0, expResp.pop_front()});
      end
    end
    if (RegWrEn || RegRdEn) begin
      if (expBus.size() == 0) begin
        totalCnt++;
        $display("FAIL unexpected_strobe: got wr=%0b rd=%0b addr=0x%0h expected none at %0t",
                 RegWrEn, RegRdEn, RegAddr, $time);
      end else begin
        op = expBus.pop_front();
        check("strobe_kind", {30'b0, RegWrEn, RegRdEn}, op.isWr ? 32'd2 : 32'd1);
        check("bus_addr", {24'b0, RegAddr}, {24'b0, op.addr});
        if (op.isWr) check("bus_wrdata", {24'b0, RegWrData}, {24'b0, op.data});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    ResetN  = 1'b0;
    TxFull  = 1'b0;
    rdValue = 8'h00;
    repeat (2) @(negedge Clock);
    check("rst_readuart",  {31'b0, ReadUart},  32'd0);
    check("rst_writeuart", {31'b0, WriteUart}, 32'd0);
    check("rst_strobes",   {30'b0, RegWrEn, RegRdEn}, 32'd0);
    check("rst_busy",      {31'b0, Busy},      32'd0);
    check("rst_writedata", {24'b0, WriteData}, 32'd0);
    check("rst_regaddr",   {24'b0, RegAddr},   32'd0);
    check("rst_regwrdata", {24'b0, RegWrData}, 32'd0);
    ResetN = 1'b1;
    repeat (2) @(negedge Clock);

    // Write
    pushRx(8'h57, 0); pushRx(8'h10, 0); pushRx(8'hA5, 0);
    expectBus(1'b1, 8'h10, 8'hA5); expResp.push_back(8'h4B);
    drain("write", 50);

    // Read
    rdValue = 8'h3C;
    pushRx(8'h52, 0); pushRx(8'h10, 0);
    expectBus(1'b0, 8'h10, 8'h00); expResp.push_back(8'h3C);
    drain("read", 50);

    // Bad opcode, then a normal read
    rdValue = 8'hC3;
    pushRx(8'h41, 0); pushRx(8'h52, 0); pushRx(8'h01, 0);
    expResp.push_back(8'h45);
    expectBus(1'b0, 8'h01, 8'h00); expResp.push_back(8'hC3);
    drain("err_then_read", 50);

    // Timeout waiting for the data byte
    pushRx(8'h57, 0); pushRx(8'h10, 0);
    expResp.push_back(8'h54);
    drain("timeout", 60);

    // Data byte on the terminal-count cycle is accepted
    pushRx(8'h57, 0); pushRx(8'h10, 0); pushRx(8'h77, 15);
    expectBus(1'b1, 8'h10, 8'h77); expResp.push_back(8'h4B);
    drain("terminal_accept", 60);

    // One cycle later times out; the late byte becomes an unknown opcode
    pushRx(8'h57, 0); pushRx(8'h22, 0); pushRx(8'h66, 16);
    expResp.push_back(8'h54); expResp.push_back(8'h45);
    drain("terminal_plus1", 60);

    // TX FIFO full during SEND
    TxFull = 1'b1;
    pushRx(8'h57, 0); pushRx(8'h20, 0); pushRx(8'h5A, 0);
    expectBus(1'b1, 8'h20, 8'h5A); expResp.push_back(8'h4B);
    repeat (10) @(negedge Clock);
    for (int i = 0; i < 40; i++) begin
      check("txfull_hold_busy", {31'b0, Busy},      32'd1);
      check("txfull_hold_data", {24'b0, WriteData}, 32'h4B);
      @(negedge Clock);
    end
    @(posedge Clock);
    #1 TxFull = 1'b0;
    @(negedge Clock);
    check("txfull_release_push", {31'b0, WriteUart}, 32'd1);
    @(negedge Clock);
    check("txfull_after_idle", {31'b0, Busy}, 32'd0);
    drain("txfull", 20);

    // Reset mid-command
    pushRx(8'h57, 0); pushRx(8'h10, 0);
    repeat (4) @(negedge Clock);
    #2 ResetN = 1'b0;
    #1;
    check("midrst_busy",      {31'b0, Busy},      32'd0);
    check("midrst_regaddr",   {24'b0, RegAddr},   32'd0);
    check("midrst_writedata", {24'b0, WriteData}, 32'd0);
    check("midrst_strobes",   {28'b0, RegWrEn, RegRdEn, WriteUart, ReadUart}, 32'd0);
    @(negedge Clock);
    ResetN = 1'b1;
    repeat (20) @(negedge Clock);
    rdValue = 8'h99;
    pushRx(8'h52, 0); pushRx(8'h10, 0);
    expectBus(1'b0, 8'h10, 8'h00); expResp.push_back(8'h99);
    drain("after_reset", 50);

    // Back-to-back commands
    rdValue = 8'h44;
    pushRx(8'h57, 0); pushRx(8'h30, 0); pushRx(8'h11, 0);
    pushRx(8'h52, 0); pushRx(8'h30, 0);
    expectBus(1'b1, 8'h30, 8'h11); expResp.push_back(8'h4B);
    expectBus(1'b0, 8'h30, 8'h00); expResp.push_back(8'h44);
    drain("back_to_back", 80);

    repeat (3) @(negedge Clock);
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
